ex_mem_latch: RTL and testbench
===============================

// Module: ex_mem_latch
// PURPOSE
//  Elastic EX/MEM pipeline register. Captures EX-stage results, including the
//  5-bit write-register number from the RegDst select, and presents them to MEM.
//  Two-entry skid buffer with valid/ready handshakes on both sides. There is no
//  combinational path from out_ready to in_ready, so MEM-side stalls do not
//  chain back into EX.
// PARAMETERS
//  DATA_W  32  width of add_result, alu_result, rdata2
//  REG_W   5   width of the write-register number (muxout)
// PORTS
//  clk             in   1       rising-edge clock
//  rst_n           in   1       async active-low reset
//  flush           in   1       squash all held entries (branch taken)
//  in_valid        in   1       EX presents a valid bundle
//  in_ready        out  1       latch can accept; = ~skid_valid (registered)
//  in_wb           in   2       {regwrite, memtoreg}
//  in_m            in   3       {branch, memread, memwrite}
//  in_add_result   in   DATA_W  branch target
//  in_zero         in   1       ALU zero flag
//  in_alu_result   in   DATA_W  ALU result / memory address
//  in_rdata2       in   DATA_W  store data
//  in_muxout       in   REG_W   selected destination register
//  out_valid       out  1       MEM-side bundle valid
//  out_ready       in   1       MEM consumes bundle
//  out_wb, out_m, out_add_result, out_zero, out_alu_result, out_rdata2,
//  out_muxout      out  as in_* fields; main-entry contents
//  occupancy       out  2       number of entries held: 0, 1 or 2
// BEHAVIOUR
//  - Handshakes:
//    - acc = in_valid & in_ready; pop = out_valid & out_ready.
//    - out_valid must not depend on in_valid in the same cycle.
//  - Reset (async, rst_n=0):
//    - all entries are cleared; state = EMPTY.
//    - out_valid=0, occupancy=0, every out_* field = 0, in_ready=1.
//  - States, encoded as occupancy (0=EMPTY, 1=ONE, 2=TWO):
//    - EMPTY: acc -> main<=in, ONE. Otherwise remain EMPTY.
//    - ONE:
//      - acc&pop -> main<=in, stay ONE.
//      - acc&!pop -> skid<=in, go to TWO.
//      - !acc&pop -> go to EMPTY.
//      - no event -> hold.
//    - TWO: in_ready=0.
//      - pop -> main<=skid, go to ONE.
//      - no pop -> hold both entries.
//  - Latency: 1 cycle from acc in EMPTY to out_valid=1. Throughput: 1 per cycle.
//  - Order: bundles are delivered strictly FIFO. None is dropped or duplicated
//    unless flush is asserted.
//  - flush=1 at an edge:
//    - next state = EMPTY regardless of acc or pop.
//    - A bundle accepted in that cycle is discarded.
//    - A pop in that cycle counts as delivered.
//    - flush has priority over all transitions.
//  - Bubble gating: while out_valid=0, out_wb and out_m read 2'b0 and 3'b0, so
//    no spurious regwrite, memread or memwrite reaches MEM.
//  - Data fields while out_valid=0 hold their last value (0 after reset).
//  - Payload is transported bit-exact; no arithmetic or width change.
//  - out_muxout is REG_W bits, zero-extension not applied.
//  - Reset asserted mid-operation: entries are lost immediately and outputs
//    follow the reset values above asynchronously.
// TESTING
//  1. Reset, then in_valid=1 with in_alu_result=32'h0000_00A4, in_muxout=5'd9,
//     out_ready=1 -> next cycle out_valid=1, out_alu_result=32'hA4,
//     out_muxout=9, occupancy=1.
//  2. out_ready=0 and three back-to-back bundles (muxout 1,2,3) ->
//     - bundles 1 and 2 are held; occupancy=2; in_ready=0; bundle 3 is stalled.
//     - After out_ready=1: pops yield muxout 1, 2, then 3, in order.
//  3. Stream of 8 bundles with out_ready=1 throughout -> one pop per cycle,
//     occupancy stays at 1, in_ready is never 0.
//  4. occupancy=2, assert flush with in_valid=1 -> next cycle out_valid=0,
//     occupancy=0, out_wb=0, out_m=0, and the flush-cycle input is not seen.
//  5. Drop rst_n mid-clock while occupancy=2 with in_wb=2'b11 held ->
//     out_valid=0, out_wb=0, out_muxout=0 immediately.
//     After release, in_ready=1.
//  6. Toggle out_ready randomly for 200 bundles (muxout = index mod 32) ->
//     the scoreboard receives all 200 in order with no loss or duplicates.

Source files
------------

// File: rtl/ex_mem_latch.sv
// EX/MEM elastic pipeline register.
// Two-entry skid buffer: the "main" entry drives the MEM side and the "skid"
// entry absorbs one extra bundle when MEM stalls. in_ready is decoded only
// from the registered state, so a MEM stall never combinationally reaches EX.
module ex_mem_latch #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_wb,
  input  logic [2:0]        in_m,
  input  logic [DATA_W-1:0] in_add_result,
  input  logic              in_zero,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_rdata2,
  input  logic [REG_W-1:0]  in_muxout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_wb,
  output logic [2:0]        out_m,
  output logic [DATA_W-1:0] out_add_result,
  output logic              out_zero,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_rdata2,
  output logic [REG_W-1:0]  out_muxout,
  output logic [1:0]        occupancy
);

  localparam int BW = 2 + 3 + DATA_W + 1 + DATA_W + DATA_W + REG_W;

  // State value doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [BW-1:0]   r_main;
  logic [BW-1:0]   r_skid;
  logic [BW-1:0]   w_in;
  logic            w_acc;
  logic            w_pop;
  logic            w_ld_main_in;
  logic            w_ld_main_skid;
  logic            w_ld_skid;

  logic [1:0]        w_main_wb;
  logic [2:0]        w_main_m;
  logic [DATA_W-1:0] w_main_add;
  logic              w_main_zero;
  logic [DATA_W-1:0] w_main_alu;
  logic [DATA_W-1:0] w_main_rd2;
  logic [REG_W-1:0]  w_main_mux;

  assign w_in = {in_wb, in_m, in_add_result, in_zero, in_alu_result, in_rdata2, in_muxout};
  assign {w_main_wb, w_main_m, w_main_add, w_main_zero, w_main_alu, w_main_rd2, w_main_mux} = r_main;

  assign in_ready  = (r_state != TWO);
  assign out_valid = (r_state != EMPTY);
  assign occupancy = r_state;
  assign w_acc     = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Control fields are gated during bubbles so MEM never sees a stray write/read.
  assign out_wb         = out_valid ? w_main_wb : 2'b00;
  assign out_m          = out_valid ? w_main_m  : 3'b000;
  assign out_add_result = w_main_add;
  assign out_zero       = w_main_zero;
  assign out_alu_result = w_main_alu;
  assign out_rdata2     = w_main_rd2;
  assign out_muxout     = w_main_mux;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_next;
  end

  // Next state and entry-load strobes; flush squashes everything, including loads.
  always_comb begin
    w_next         = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_ld_main_in = 1'b1;
          w_next       = ONE;
        end
      end
      ONE: begin
        if (w_acc && w_pop) begin
          w_ld_main_in = 1'b1;
        end else if (w_acc) begin
          w_ld_skid = 1'b1;
          w_next    = TWO;
        end else if (w_pop) begin
          w_next = EMPTY;
        end
      end
      TWO: begin
        if (w_pop) begin
          w_ld_main_skid = 1'b1;
          w_next         = ONE;
        end
      end
      default: w_next = EMPTY;
    endcase
    if (flush) begin
      w_next         = EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
    end
  end

  // Main entry: loads from EX directly or from the skid entry; otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_main <= '0;
    else if (w_ld_main_in)   r_main <= w_in;
    else if (w_ld_main_skid) r_main <= r_skid;
  end

  // Skid entry: captures the bundle that arrives while MEM is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_skid <= '0;
    else if (w_ld_skid) r_skid <= w_in;
  end

endmodule

// File: tb/tb_ex_mem_latch.sv
// Testbench for ex_mem_latch: directed scenarios plus a randomized stream,
// compared against a queue-based model of the buffer.
module tb_ex_mem_latch;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic [1:0]        wb;
    logic [2:0]        m;
    logic [DATA_W-1:0] add;
    logic              zero;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rd2;
    logic [REG_W-1:0]  mux;
  } bundle_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic out_valid;
  logic out_ready = 1'b0;
  bundle_t bin = '0;
  logic [1:0]        out_wb;
  logic [2:0]        out_m;
  logic [DATA_W-1:0] out_add_result;
  logic              out_zero;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_rdata2;
  logic [REG_W-1:0]  out_muxout;
  logic [1:0]        occupancy;

  int n_chk = 0;
  int n_fail = 0;

  bundle_t q[$];
  bundle_t head_hold = '0;
  logic [REG_W-1:0] got[$];

  always #5 clk = ~clk;

  ex_mem_latch #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wb(bin.wb), .in_m(bin.m), .in_add_result(bin.add), .in_zero(bin.zero),
    .in_alu_result(bin.alu), .in_rdata2(bin.rd2), .in_muxout(bin.mux),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wb(out_wb), .out_m(out_m), .out_add_result(out_add_result),
    .out_zero(out_zero), .out_alu_result(out_alu_result),
    .out_rdata2(out_rdata2), .out_muxout(out_muxout), .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bundle_t rnd_bundle(input logic [REG_W-1:0] mux);
    bundle_t b;
    b.wb   = 2'($urandom);
    b.m    = 3'($urandom);
    b.add  = $urandom;
    b.zero = 1'($urandom);
    b.alu  = $urandom;
    b.rd2  = $urandom;
    b.mux  = mux;
    return b;
  endfunction

  // Compare every DUT output with the model's view.
  task automatic check_all(input string tag);
    logic v;
    v = (q.size() > 0);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".occ"},   64'(occupancy), 64'(q.size()));
    chk({tag, ".rdy"},   64'(in_ready),  64'(q.size() < 2));
    chk({tag, ".wb"},    64'(out_wb),    v ? 64'(head_hold.wb) : 64'(0));
    chk({tag, ".m"},     64'(out_m),     v ? 64'(head_hold.m)  : 64'(0));
    chk({tag, ".add"},   64'(out_add_result), 64'(head_hold.add));
    chk({tag, ".zero"},  64'(out_zero),       64'(head_hold.zero));
    chk({tag, ".alu"},   64'(out_alu_result), 64'(head_hold.alu));
    chk({tag, ".rd2"},   64'(out_rdata2),     64'(head_hold.rd2));
    chk({tag, ".mux"},   64'(out_muxout),     64'(head_hold.mux));
  endtask

  // One clock: drive inputs, record a DUT delivery, advance model, check.
  task automatic step(input string tag, input bit v, input bit rdy, input bit fl, input bundle_t b);
    bit acc, pop;
    in_valid  = v;
    out_ready = rdy;
    flush     = fl;
    bin       = b;
    #1;
    if (out_valid && out_ready) got.push_back(out_muxout);
    acc = v && (q.size() < 2);
    pop = rdy && (q.size() > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    if (q.size() > 0) head_hold = q[0];
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    head_hold = '0;
  endtask

  initial begin
    bundle_t b;
    int idx, cyc;
    logic [REG_W-1:0] exp_list[$];

    // Reset state
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single bundle, one-cycle latency
    b = rnd_bundle(5'd9);
    b.alu = 32'h0000_00A4;
    step("t1", 1, 1, 0, b);
    chk("t1.alu_lit", 64'(out_alu_result), 64'h0000_00A4);
    chk("t1.mux_lit", 64'(out_muxout), 64'd9);
    chk("t1.occ_lit", 64'(occupancy), 64'd1);
    step("t1d", 0, 1, 0, rnd_bundle(5'd0));

    // 2: stall with three back-to-back bundles, then drain in order
    got.delete();
    step("t2a", 1, 0, 0, rnd_bundle(5'd1));
    step("t2b", 1, 0, 0, rnd_bundle(5'd2));
    b = rnd_bundle(5'd3);
    step("t2c", 1, 0, 0, b);
    chk("t2.full_occ", 64'(occupancy), 64'd2);
    chk("t2.full_rdy", 64'(in_ready), 64'd0);
    step("t2d", 1, 1, 0, b);
    step("t2e", 1, 1, 0, b);
    step("t2f", 0, 1, 0, rnd_bundle(5'd0));
    step("t2g", 0, 1, 0, rnd_bundle(5'd0));
    chk("t2.count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3 && i < got.size(); i++)
      chk("t2.order", 64'(got[i]), 64'(i + 1));

    // 3: full-rate stream
    for (int i = 0; i < 8; i++) begin
      step("t3", 1, 1, 0, rnd_bundle(5'(i + 10)));
      chk("t3.occ1", 64'(occupancy), 64'd1);
    end
    step("t3d", 0, 1, 0, rnd_bundle(5'd0));

    // 4: flush while full, with a new bundle offered
    step("t4a", 1, 0, 0, rnd_bundle(5'd20));
    step("t4b", 1, 0, 0, rnd_bundle(5'd21));
    b = rnd_bundle(5'd22);
    b.wb = 2'b11;
    b.m  = 3'b111;
    step("t4f", 1, 0, 1, b);
    chk("t4.valid", 64'(out_valid), 64'd0);
    chk("t4.wb", 64'(out_wb), 64'd0);
    step("t4i", 0, 0, 0, rnd_bundle(5'd0));

    // 5: asynchronous reset while full
    b = rnd_bundle(5'd5);
    b.wb = 2'b11;
    step("t5a", 1, 0, 0, b);
    b.mux = 5'd6;
    step("t5b", 1, 0, 0, b);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("t5rst");
    chk("t5.wb0", 64'(out_wb), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5.rdy", 64'(in_ready), 64'd1);
    check_all("t5rel");

    // 6: 200 bundles with random back-pressure
    got.delete();
    exp_list.delete();
    idx = 0;
    cyc = 0;
    b = rnd_bundle(5'd0);
    while ((idx < 200 || q.size() > 0) && cyc < 3000) begin
      if (idx < 200) begin
        b.mux = 5'(idx % 32);
        if (q.size() < 2) begin
          exp_list.push_back(b.mux);
          idx++;
        end
        step("t6", 1, 1'($urandom), 0, b);
        if (q.size() > 0 && q[q.size()-1] == b) b = rnd_bundle(5'd0);
      end else begin
        step("t6d", 0, 1'($urandom), 0, rnd_bundle(5'd0));
      end
      cyc++;
    end
    chk("t6.timeout", 64'(cyc < 3000), 64'd1);
    chk("t6.count", 64'(got.size()), 64'd200);
    for (int i = 0; i < 200 && i < got.size(); i++)
      chk("t6.order", 64'(got[i]), 64'(i % 32));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
